// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, state encoding, zeta ROM and modular helpers for ntt_engine
package ntt_pkg;
  localparam int N = 256;
  localparam int CW = 12;
  localparam logic [12:0] Q = 13'd3329;
  localparam logic [CW-1:0] N_INV = 12'd3303;
  typedef logic [CW-1:0] coef_t;
  typedef logic [2:0] state_t;
  localparam state_t IDLE     = 3'd0;
  localparam state_t LOAD     = 3'd1;
  localparam state_t BF_READ  = 3'd2;
  localparam state_t BF_WRITE = 3'd3;
  localparam state_t SCALE    = 3'd4;
  localparam state_t UNLOAD   = 3'd5;
  // 17^bitrev7(i) mod Q, i = 0..127
  localparam coef_t ZETAS [128] = '{
    12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
    12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
    12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
    12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
    12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
    12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
    12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
    12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
    12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
    12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
    12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
    12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
    12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
    12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
    12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
    12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
  };
  function automatic coef_t mod_q_add(input coef_t a, input coef_t b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= Q ? coef_t'(s - Q) : coef_t'(s);
  endfunction
  function automatic coef_t mod_q_sub(input coef_t a, input coef_t b);
    logic [12:0] s;
    s = {1'b0, a} - {1'b0, b};
    return a < b ? coef_t'(s + Q) : coef_t'(s);
  endfunction
  function automatic coef_t mul_mod(input coef_t a, input coef_t b);
    logic [23:0] p;
    p = {12'd0, a} * {12'd0, b};
    return coef_t'(p % {11'd0, Q});
  endfunction
endpackage

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: combinational CT (forward) / GS (inverse) butterfly sharing one modular multiplier
module ntt_butterfly
  import ntt_pkg::*;
(
  input  logic          inv,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic [CW-1:0] zeta,
  output logic [CW-1:0] a_out,
  output logic [CW-1:0] b_out
);
  coef_t m, t;
  // forward multiplies the upper operand, inverse multiplies the difference
  always_comb begin
    m = inv ? mod_q_sub(b, a) : b;
    t = mul_mod(zeta, m);
    a_out = inv ? mod_q_add(a, b) : mod_q_add(a, t);
    b_out = inv ? t : mod_q_sub(a, t);
  end
endmodule

// File: rtl/ntt_engine.sv
// ntt_engine: streaming forward/inverse NTT over Z_3329[X]/(X^256+1); NTT_ENGINE_INVERSE_EN builds the inverse path and SCALE
module ntt_engine
  import ntt_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             inverse,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             done
);
`ifdef NTT_ENGINE_INVERSE_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif
  localparam logic [8:0] LAST = 9'(N - 1);
  localparam logic [8:0] ALL = 9'(N);
  localparam logic signed [IN_W+1:0] QS = $signed((IN_W + 2)'(Q));
  state_t state;
  logic inv, blk_end, last_layer;
  logic [8:0] cnt, j_step, j_nxt;
  logic [7:0] j, len, jl;
  logic [6:0] k;
  logic signed [IN_W+1:0] rem;
  coef_t ram [N];
  coef_t a, b, a_o, b_o, load_val;
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  // input reduction into [0, Q-1] and next butterfly index (skip the upper half at a block end)
  always_comb begin
    rem = $signed({{2{in_data[IN_W-1]}}, in_data}) % QS;
    load_val = coef_t'(rem[IN_W+1] ? rem + QS : rem);
    jl = j + len;
    j_step = {1'b0, j} + 9'd1;
    blk_end = |(j_step[7:0] & len);
    j_nxt = blk_end ? j_step + {1'b0, len} : j_step;
    last_layer = inv ? len == 8'd128 : len == 8'd2;
  end
  ntt_butterfly u_bf (
    .inv  (inv),
    .a    (a),
    .b    (b),
    .zeta (ZETAS[k]),
    .a_out(a_o),
    .b_out(b_o)
  );
  // coefficient RAM: streamed load, butterfly write-back, inverse scaling
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) ram[cnt[7:0]] <= load_val;
    if (state == BF_WRITE) begin
      ram[j] <= a_o;
      ram[jl] <= b_o;
    end
`ifdef NTT_ENGINE_INVERSE_EN
    if (state == SCALE) ram[cnt[7:0]] <= mul_mod(ram[cnt[7:0]], N_INV);
`endif
  end
  // job sequencing, layer/block counters and the registered output stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      inv <= 1'b0;
      cnt <= '0;
      j <= '0;
      len <= '0;
      k <= '0;
      a <= '0;
      b <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          inv <= inverse & INV_EN;
          cnt <= '0;
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + 9'd1;
          if (cnt == LAST) begin
            state <= BF_READ;
            cnt <= '0;
            j <= '0;
            len <= inv ? 8'd2 : 8'd128;
            k <= inv ? 7'd127 : 7'd1;
          end
        end
        BF_READ: begin
          a <= ram[j];
          b <= ram[jl];
          state <= BF_WRITE;
        end
        BF_WRITE: begin
          j <= j_nxt[7:0];
          k <= blk_end ? (inv ? k - 7'd1 : k + 7'd1) : k;
          len <= j_nxt[8] ? (inv ? len << 1 : len >> 1) : len;
          state <= j_nxt[8] && last_layer ? (inv ? SCALE : UNLOAD) : BF_READ;
        end
`ifdef NTT_ENGINE_INVERSE_EN
        SCALE: begin
          cnt <= cnt + 9'd1;
          if (cnt == LAST) begin
            state <= UNLOAD;
            cnt <= '0;
          end
        end
`endif
        UNLOAD: if (!out_valid || out_ready) begin
          if (out_valid && cnt == ALL) begin
            out_valid <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
            cnt <= '0;
          end else begin
            out_data <= OUT_W'(ram[cnt[7:0]]);
            out_valid <= 1'b1;
            cnt <= cnt + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_engine.sv
// tb_ntt_engine: table-driven NTT jobs checked against a reference model through an output scoreboard
module tb_ntt_engine;
`ifdef NTT_ENGINE_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif
  typedef struct {
    string name;
    logic  inv;
    int    src;
    logic  stall;
  } vec_t;
  logic clk = 0, reset_n = 0, start = 0, inverse = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, busy, done;
  logic [11:0] out_data;
  int total = 0, bad = 0, cyc = 0, c0 = 0;
  int zeta [128];
  int cur_in [256];
  int rnd [256];
  int saved [256];
  int exp_v [256];
  int q [$];
  vec_t tv [6];
  ntt_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .inverse(inverse),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    end
  endtask
  function automatic int md(input int x);
    return ((x % 3329) + 3329) % 3329;
  endfunction
  function automatic int pw(input int bs, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * bs % 3329;
    return r;
  endfunction
  function automatic int br7(input int x);
    int r = 0;
    for (int i = 0; i < 7; i++) if (((x >> i) & 1) == 1) r |= 1 << (6 - i);
    return r;
  endfunction
  function automatic vec_t mk(input string nm, input logic iv, input int s, input logic st);
    vec_t v;
    v.name = nm;
    v.inv = iv;
    v.src = s;
    v.stall = st;
    return v;
  endfunction
  task automatic model_fwd();
    int f [256];
    int kk;
    kk = 1;
    for (int i = 0; i < 256; i++) f[i] = md(cur_in[i]);
    for (int ln = 128; ln >= 2; ln /= 2) begin
      for (int st = 0; st < 256; st += 2 * ln) begin
        int z;
        z = zeta[kk];
        kk++;
        for (int jj = st; jj < st + ln; jj++) begin
          int t;
          t = z * f[jj + ln] % 3329;
          f[jj + ln] = md(f[jj] - t);
          f[jj] = md(f[jj] + t);
        end
      end
    end
    for (int i = 0; i < 256; i++) exp_v[i] = f[i];
  endtask
  task automatic load_job(input vec_t v);
    int w;
    for (int i = 0; i < 256; i++)
      cur_in[i] = v.src == 0 ? (i == 0 ? 1 : 0) : v.src == 1 ? (i == 1 ? 1 : 0) :
                  v.src == 2 ? -1 : v.src == 3 ? rnd[i] : saved[i];
    @(negedge clk);
    start = 1;
    inverse = v.inv;
    @(negedge clk);
    start = 0;
    check({v.name, " busy_on_start"}, busy, 1);
    for (int i = 0; i < 256; i++) begin
      w = 0;
      in_valid = 1;
      in_data = 16'(cur_in[i]);
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        check({v.name, " in_ready_wait"}, in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 0;
    c0 = cyc;
    check({v.name, " in_ready_drop"}, in_ready, 0);
  endtask
  task automatic unload_job(input vec_t v);
    int n, w, hold, dn, e, lat;
    logic rdy, pend, first;
    logic [11:0] pdata;
    if (v.src == 4 && v.inv && INV_EN) for (int i = 0; i < 256; i++) exp_v[i] = md(rnd[i]);
    else model_fwd();
    for (int i = 0; i < 256; i++) q.push_back(exp_v[i]);
    lat = (v.inv && INV_EN) ? 2049 : 1793;
    n = 0; w = 0; hold = 0; dn = 0; rdy = 1; pend = 0; first = 1; pdata = '0;
    while (n < 256 && w < 6000) begin
      if (pend) begin
        check({v.name, " stall_valid"}, out_valid, 1);
        check({v.name, " stall_data"}, out_data, pdata);
      end
      if (out_valid && first) begin
        check({v.name, " latency"}, cyc - c0, lat);
        first = 0;
      end
      if (v.stall) begin
        if (n == 100 && out_valid && hold < 50) begin
          rdy = 0;
          hold++;
        end else rdy = ~rdy;
      end else rdy = 1;
      out_ready = rdy;
      pend = out_valid && !rdy;
      pdata = out_data;
      if (out_valid && rdy) begin
        e = q.pop_front();
        check($sformatf("%s out[%0d]", v.name, n), out_data, e);
        if (v.stall) check($sformatf("%s vs_plain[%0d]", v.name, n), out_data, saved[n]);
        else if (v.src == 3) saved[n] = out_data;
        n++;
      end
      if (done) dn++;
      @(negedge clk);
      w++;
    end
    out_ready = 0;
    if (n < 256) begin
      check({v.name, " drained"}, n, 256);
      q.delete();
    end else begin
      if (done) dn++;
      check({v.name, " done_pulse"}, done, 1);
      check({v.name, " valid_end"}, out_valid, 0);
      check({v.name, " busy_end"}, busy, 0);
      @(negedge clk);
      check({v.name, " done_low"}, done, 0);
      check({v.name, " done_count"}, dn, 1);
    end
  endtask
  task automatic run_job(input vec_t v);
    load_job(v);
    unload_job(v);
  endtask
  initial begin
    vec_t rv;
    for (int i = 0; i < 128; i++) zeta[i] = pw(17, br7(i));
    for (int i = 0; i < 256; i++) rnd[i] = int'($urandom_range(0, 3328)) - 1664;
    tv[0] = mk("fwd_delta", 1'b0, 0, 1'b0);
    tv[1] = mk("fwd_x", 1'b0, 1, 1'b0);
    tv[2] = mk("fwd_neg1", 1'b0, 2, 1'b0);
    tv[3] = mk("fwd_rand", 1'b0, 3, 1'b0);
    tv[4] = mk("rt_inverse", 1'b1, 4, 1'b0);
    tv[5] = mk("bp_rand", 1'b0, 3, 1'b1);
    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run_job(tv[i]);
    rv = mk("rst_delta", 1'b0, 0, 1'b0);
    load_job(rv);
    repeat (601) @(negedge clk);
    start = 1;
    inverse = 1;
    @(negedge clk);
    check("midjob start_ignored", in_ready, 0);
    check("midjob busy", busy, 1);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst done", done, 0);
    start = 0;
    inverse = 0;
    repeat (2) @(negedge clk);
    check("midrst busy_held", busy, 0);
    reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst done", done, 0);
      check("post_rst busy", busy, 0);
    end
    run_job(rv);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
